// File: rtl/ternary_pkg.sv
// Shared ternary types: digit encoding, digit constants and the serial-adder FSM states.
package ternary_pkg;

   typedef logic [1:0] digit_t;

   localparam digit_t T0   = 2'b00;
   localparam digit_t T1   = 2'b01;
   localparam digit_t T2   = 2'b10;
   localparam digit_t TBAD = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_t;

   // True for the one code that does not represent a ternary digit.
   function automatic logic is_bad_digit(input digit_t d);
      return (d == TBAD);
   endfunction

endpackage

// File: rtl/ternary_full_adder_1digit.sv
// One-digit ternary full adder built from two half adders.
// Worst case 2+2+1 = 12 (base 3), so the two partial carries never coincide
// and a plain OR yields the slice carry.
module ternary_full_adder_1digit
   import ternary_pkg::*;
(
   input  digit_t x,
   input  digit_t y,
   input  logic   cin,
   output digit_t s,
   output logic   cout
);

   digit_t s1;
   logic   c1;
   logic   c2;
   digit_t cin_digit;

   assign cin_digit = cin ? T1 : T0;

   ternary_half_adder_1digit u_ha_xy (
      .x (x),
      .y (y),
      .s (s1),
      .c (c1)
   );

   ternary_half_adder_1digit u_ha_cin (
      .x (s1),
      .y (cin_digit),
      .s (s),
      .c (c2)
   );

   assign cout = c1 | c2;

endmodule

// File: rtl/ternary_half_adder_1digit.sv
// One-digit ternary half adder: s = (x+y) mod 3, c = (x+y) >= 3.
// Output for the illegal code is don't-care; callers flag and discard it.
module ternary_half_adder_1digit
   import ternary_pkg::*;
(
   input  digit_t x,
   input  digit_t y,
   output digit_t s,
   output logic   c
);

   logic [2:0] total;

   // Add the two digit values and fold anything at or above 3 into a carry.
   always_comb begin
      total = {1'b0, x} + {1'b0, y};
      if (total >= 3'd3) begin
         s = digit_t'(total - 3'd3);
         c = 1'b1;
      end else begin
         s = digit_t'(total);
         c = 1'b0;
      end
   end

endmodule

// File: rtl/ternary_serial_adder.sv
// Digit-serial ternary adder: N digits, LSD first, one digit per clock.
// Start is taken only in IDLE; results are published on the DONE cycle and
// held until the following operation completes.
module ternary_serial_adder
   import ternary_pkg::*;
#(
   parameter int N = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [2*N-1:0] a,
   input  logic [2*N-1:0] b,
   output logic           ready,
   output logic           done,
   output logic [2*N-1:0] sum,
   output logic           cout,
   output logic           err
);

   localparam int CW = $clog2(N + 1);
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   state_t         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [2*N-1:0] opa_q, opa_d;
   logic [2*N-1:0] opb_q, opb_d;
   logic [2*N-1:0] res_q, res_d;
   logic           carry_q, carry_d;
   logic           bad_q, bad_d;
   logic           ready_q, ready_d;
   logic           done_q, done_d;
   logic [2*N-1:0] sum_q, sum_d;
   logic           cout_q, cout_d;
   logic           err_q, err_d;

   digit_t         slice_s;
   logic           slice_c;
   logic [2*N+1:0] res_ext;

   // True if any digit of the operand carries the illegal code.
   function automatic logic has_bad(input logic [2*N-1:0] v);
      logic bad;
      bad = 1'b0;
      for (int i = 0; i < N; i++) begin
         bad = bad | is_bad_digit(v[2*i +: 2]);
      end
      return bad;
   endfunction

   ternary_full_adder_1digit u_slice (
      .x    (opa_q[1:0]),
      .y    (opb_q[1:0]),
      .cin  (carry_q),
      .s    (slice_s),
      .cout (slice_c)
   );

   // Next-state and datapath: load on start, shift one digit per ADD cycle,
   // publish (or force to zero on illegal input) at the last digit.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      res_d   = res_q;
      carry_d = carry_q;
      bad_d   = bad_q;
      ready_d = ready_q;
      done_d  = 1'b0;
      sum_d   = sum_q;
      cout_d  = cout_q;
      err_d   = err_q;
      res_ext = {slice_s, res_q};

      case (state_q)
         IDLE: begin
            ready_d = 1'b1;
            if (start) begin
               opa_d   = a;
               opb_d   = b;
               res_d   = '0;
               carry_d = 1'b0;
               cnt_d   = '0;
               bad_d   = has_bad(a) | has_bad(b);
               ready_d = 1'b0;
               state_d = ADD;
            end
         end
         ADD: begin
            opa_d   = opa_q >> 2;
            opb_d   = opb_q >> 2;
            res_d   = res_ext[2*N+1:2];
            carry_d = slice_c;
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               state_d = DONE;
               done_d  = 1'b1;
               sum_d   = bad_q ? '0 : res_ext[2*N+1:2];
               cout_d  = bad_q ? 1'b0 : slice_c;
               err_d   = bad_q;
            end
         end
         DONE: begin
            state_d = IDLE;
            ready_d = 1'b1;
         end
         default: begin
            state_d = IDLE;
            ready_d = 1'b1;
         end
      endcase
   end

   // State, datapath and registered outputs; reset abandons any operation.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         opa_q   <= '0;
         opb_q   <= '0;
         res_q   <= '0;
         carry_q <= 1'b0;
         bad_q   <= 1'b0;
         ready_q <= 1'b1;
         done_q  <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         res_q   <= res_d;
         carry_q <= carry_d;
         bad_q   <= bad_d;
         ready_q <= ready_d;
         done_q  <= done_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         err_q   <= err_d;
      end
   end

   assign ready = ready_q;
   assign done  = done_q;
   assign sum   = sum_q;
   assign cout  = cout_q;
   assign err   = err_q;

endmodule

// File: tb/tb_ternary_serial_adder.sv
// Bench for ternary_serial_adder: directed cases plus random legal operands
// for N=4 and N=1 against a base-3 integer model.
module tb_ternary_serial_adder;

   logic       clk;
   logic       rst;

   logic       start4, ready4, done4, cout4, err4;
   logic [7:0] a4, b4, sum4;

   logic       start1, ready1, done1, cout1, err1;
   logic [1:0] a1, b1, sum1;

   int checks;
   int failures;

   ternary_serial_adder #(.N(4)) dut4 (
      .clk   (clk),
      .rst   (rst),
      .start (start4),
      .a     (a4),
      .b     (b4),
      .ready (ready4),
      .done  (done4),
      .sum   (sum4),
      .cout  (cout4),
      .err   (err4)
   );

   ternary_serial_adder #(.N(1)) dut1 (
      .clk   (clk),
      .rst   (rst),
      .start (start1),
      .a     (a1),
      .b     (b1),
      .ready (ready1),
      .done  (done1),
      .sum   (sum1),
      .cout  (cout1),
      .err   (err1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   // Reference: value the operands as base-3 integers, add, re-encode.
   // Returns {cout, sum digits} with the sum in the low 2n bits.
   function automatic logic [8:0] tern_add(input int n, input logic [7:0] x, input logic [7:0] y);
      int vx, vy, p, tot;
      logic [8:0] r;
      vx = 0; vy = 0; p = 1; r = '0;
      for (int i = 0; i < n; i++) begin
         vx += int'(x[2*i +: 2]) * p;
         vy += int'(y[2*i +: 2]) * p;
         p  *= 3;
      end
      tot  = vx + vy;
      r[8] = (tot >= p);
      tot  = tot % p;
      for (int i = 0; i < n; i++) begin
         r[2*i +: 2] = 2'(tot % 3);
         tot = tot / 3;
      end
      return r;
   endfunction

   function automatic logic [7:0] rand_legal(input int n);
      logic [7:0] v;
      v = '0;
      for (int i = 0; i < n; i++) v[2*i +: 2] = 2'($urandom_range(0, 2));
      return v;
   endfunction

   // One N=4 operation; entered #1 after an edge with the DUT idle.
   // lat counts edges from the one sampling start to the done cycle (0 = timeout).
   task automatic run4(input logic [7:0] ta, input logic [7:0] tb_, output logic [7:0] rs,
                       output logic rc, output logic re, output int lat);
      a4 = ta; b4 = tb_; start4 = 1'b1;
      lat = 0; rs = '0; rc = 1'b0; re = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk); #1;
         start4 = 1'b0;
         if (done4) begin
            lat = k; rs = sum4; rc = cout4; re = err4;
            break;
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic run1(input logic [1:0] ta, input logic [1:0] tb_, output logic [1:0] rs,
                       output logic rc, output int lat);
      a1 = ta; b1 = tb_; start1 = 1'b1;
      lat = 0; rs = '0; rc = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         @(posedge clk); #1;
         start1 = 1'b0;
         if (done1) begin
            lat = k; rs = sum1; rc = cout1;
            break;
         end
      end
      @(posedge clk); #1;
   endtask

   initial begin
      logic [7:0] rs, ra, rb;
      logic [8:0] m;
      logic [1:0] rs1;
      logic       rc, re;
      int         lat, ndone;

      checks = 0; failures = 0;
      rst = 1'b1; start4 = 1'b0; start1 = 1'b0;
      a4 = '0; b4 = '0; a1 = '0; b1 = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      chk("rst_ready", ready4, 1'b1);
      chk("rst_done",  done4,  1'b0);
      chk("rst_sum",   sum4,   8'h00);
      chk("rst_cout",  cout4,  1'b0);
      chk("rst_err",   err4,   1'b0);

      // 0102 + 0011 = 0120, with ready dropping during the operation.
      a4 = 8'h12; b4 = 8'h05; start4 = 1'b1;
      @(posedge clk); #1 start4 = 1'b0;
      chk("busy_ready", ready4, 1'b0);
      lat = 0;
      for (int k = 2; k <= 20; k++) begin
         @(posedge clk); #1;
         if (done4) begin lat = k; break; end
      end
      chk("basic_lat",  lat,   5);
      chk("basic_sum",  sum4,  8'h18);
      chk("basic_cout", cout4, 1'b0);
      chk("basic_err",  err4,  1'b0);
      @(posedge clk); #1;
      chk("basic_done_pulse", done4,  1'b0);
      chk("basic_ready_back", ready4, 1'b1);
      chk("basic_sum_hold",   sum4,   8'h18);

      // 2222 + 0001: carry ripples through every digit.
      run4(8'hAA, 8'h01, rs, rc, re, lat);
      chk("ripple_lat",  lat, 5);
      chk("ripple_sum",  rs,  8'h00);
      chk("ripple_cout", rc,  1'b1);

      // Illegal digit: zeros forced, err raised, next legal op clears err.
      run4(8'h03, 8'h00, rs, rc, re, lat);
      chk("bad_lat",  lat, 5);
      chk("bad_sum",  rs,  8'h00);
      chk("bad_cout", rc,  1'b0);
      chk("bad_err",  re,  1'b1);
      chk("bad_err_hold", err4, 1'b1);
      run4(8'h12, 8'h05, rs, rc, re, lat);
      chk("clr_err", re, 1'b0);
      chk("clr_sum", rs, 8'h18);

      // Start held through ADD and DONE with changed operands: one op only.
      a4 = 8'h12; b4 = 8'h05; start4 = 1'b1; ndone = 0; rs = '0;
      for (int k = 1; k <= 12; k++) begin
         @(posedge clk); #1;
         if (k == 1) begin a4 = 8'hAA; b4 = 8'hAA; end
         if (k == 6) start4 = 1'b0;
         if (done4) begin ndone++; rs = sum4; end
      end
      chk("restart_ndone", ndone, 1);
      chk("restart_sum",   rs,    8'h18);

      // Reset during the second ADD cycle of 0202 + 0202.
      a4 = 8'h22; b4 = 8'h22; start4 = 1'b1;
      @(posedge clk); #1 start4 = 1'b0;
      @(posedge clk); #1 rst = 1'b1;
      #1;
      chk("midrst_ready", ready4, 1'b1);
      chk("midrst_done",  done4,  1'b0);
      chk("midrst_sum",   sum4,   8'h00);
      chk("midrst_cout",  cout4,  1'b0);
      #2 rst = 1'b0;
      ndone = 0;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk); #1;
         if (done4) ndone++;
      end
      chk("midrst_no_done", ndone, 0);
      run4(8'h22, 8'h22, rs, rc, re, lat);
      m = tern_add(4, 8'h22, 8'h22);
      chk("postrst_sum",  rs, m[7:0]);
      chk("postrst_cout", rc, m[8]);

      // Random legal operands, N=4.
      for (int t = 0; t < 30; t++) begin
         ra = rand_legal(4);
         rb = rand_legal(4);
         m  = tern_add(4, ra, rb);
         run4(ra, rb, rs, rc, re, lat);
         chk("rnd4_lat",  lat, 5);
         chk("rnd4_sum",  rs,  m[7:0]);
         chk("rnd4_cout", rc,  m[8]);
         chk("rnd4_err",  re,  1'b0);
      end

      // Random legal operands, N=1.
      for (int t = 0; t < 20; t++) begin
         ra = rand_legal(1);
         rb = rand_legal(1);
         m  = tern_add(1, ra, rb);
         run1(ra[1:0], rb[1:0], rs1, rc, lat);
         chk("rnd1_lat",  lat, 2);
         chk("rnd1_sum",  rs1, m[1:0]);
         chk("rnd1_cout", rc,  m[8]);
      end
      chk("n1_err", err1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ternary_serial_adder.md
# ternary_serial_adder

Digit-serial adder for two N-digit ternary operands, one digit per clock, least-significant digit first. It sits directly downstream of the team's 1-digit ternary half adder. It chains two of those half adders into a full-adder digit slice and wraps that slice in a load / shift / carry-register datapath with a start/done handshake. Result and final carry are registered and held until the next operation.

## Interface
- N, default 4: number of ternary digits per operand (N ≥ 1).
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only while ready=1.
- a  input  2N  operand A; digit i at bits [2i+1:2i].
- b  input  2N  operand B; same packing as A.
- ready  output  1  high in IDLE only.
- done  output  1  one-cycle pulse; sum, cout and err are valid from this cycle on.
- sum  output  2N  result digits, same packing as A.
- cout  output  1  carry out of digit N-1.
- err  output  1  an illegal digit code was present in a or b at load.

## Operation
- Digit encoding: 2'b00=0, 2'b01=1, 2'b10=2, 2'b11=illegal.
- Digit slice: first half adder computes a_i+b_i, giving s1 and c1. Second half adder adds s1 and the carry register, with carry as 2'b01 when set, giving s and c2.
  - Slice carry = c1|c2. c1 and c2 are never both 1; the maximum is 2+2+1 = 12₃.
- FSM states and transitions:
  - IDLE: if start, load a and b into shift registers, clear the carry register and digit counter, capture err, go to ADD.
  - ADD: each cycle, process the low digit, shift both operand registers right by 2, shift the result digit into the MSB end of the sum shift register, update carry and increment the counter. After the N-th digit, go to DONE.
  - DONE: one cycle; done=1; go to IDLE.
- err=1 at load: datapath still runs for N cycles; at DONE, sum=0 and cout=0 are forced and err=1.
  - err is held until the next accepted start.
- Start in ADD or DONE is ignored, with no queuing.
- sum, cout and err hold their values from DONE until the next accepted start. They are then updated only at the next DONE; intermediate shifting happens in internal registers.

## Timing
- Reset values: state=IDLE, ready=1, done=0, sum=0, cout=0, err=0; carry, counter and shift registers are 0.
- Latency: start high in cycle c gives ADD in cycles c+1 … c+N and done in cycle c+N+1. ready returns high in cycle c+N+2.
- Throughput: one operation per N+2 cycles.
- rst asserted mid-ADD: the operation is abandoned immediately and all outputs take their reset values. No done pulse follows.
- N=1: a single ADD cycle, then DONE.

## Structure
- Shared package ternary_pkg holds:
  - digit typedef: 2-bit logic;
  - constants T0=2'b00, T1=2'b01, T2=2'b10, TBAD=2'b11;
  - FSM state enum {IDLE, ADD, DONE}.
- Sub-module ternary_full_adder_1digit (combinational): inputs x, y and cin; outputs s and cout. It is built from two half-adder instances plus an OR.
- The top level holds the FSM, a $clog2(N+1)-bit counter, the operand and result shift registers and the carry register.

## Test plan
- N=4, a=8'h12 (0102₃), b=8'h05 (0011₃), start for 1 cycle -> done 5 cycles later; sum=8'h18 (0120₃), cout=0, err=0.
- a=8'hAA (2222₃), b=8'h01 -> sum=8'h00, cout=1. Carry ripples through all digits.
- a=8'h03 (digit 0 illegal), b=8'h00 -> done after 5 cycles with err=1, sum=0, cout=0. The next legal start clears err.
- start re-pulsed during ADD and in the DONE cycle -> ignored; exactly one done; results match the first operands.
- rst pulsed in the 2nd ADD cycle -> ready=1, done=0, sum=0, cout=0 immediately. A subsequent start computes correctly from a cleared carry.
- Randomised legal operands for N=1 and N=4, compared against a base-3 integer model; illegal codes are never generated in this scenario.
